// File: rtl/lc3b_types.sv
// Shared LC-3b types; the memory responder adds its byte-mask and FSM state types here.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;
  typedef logic [14:0] lc3b_word_index;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } lc3b_memresp_state;

endpackage

// File: rtl/lc3b_byte_ram.sv
// DEPTH_WORDS x 16 word array with per-byte write enables and a registered,
// enable-gated read port. Array contents are never reset; only the read register is.
module lc3b_byte_ram
  import lc3b_types::*;
#(
  parameter  int unsigned DEPTH_WORDS = 256,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  input  lc3b_mem_wmask         wr_be,
  input  logic [AW-1:0]         wr_addr,
  input  lc3b_word              wdata,
  output lc3b_word              rdata
);

  logic [1:0][7:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_be[0]) mem[wr_addr][0] <= wdata[7:0];
    if (wr_be[1]) mem[wr_addr][1] <= wdata[15:8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rdata <= '0;
    else if (rd_en) rdata <= mem[rd_addr];
  end

endmodule

// File: rtl/lc3b_mem_responder.sv
// Fixed-latency memory responder for the LC-3b memory port.
// Optional range check enabled by defining LC3B_MEMRESP_RANGECHK_EN (adds mem_err).
module lc3b_mem_responder
  import lc3b_types::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_mem_wmask mem_wmask,
  input  lc3b_word      mem_address,
  input  lc3b_word      mem_wdata,
  output lc3b_word      mem_rdata,
  output logic          mem_resp
`ifdef LC3B_MEMRESP_RANGECHK_EN
  ,
  output logic          mem_err
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;

  lc3b_memresp_state state, next_state;
  logic [CW-1:0]     cnt;
  logic              write_q;
  lc3b_word_index    idx_q;
  lc3b_word          wdata_q;
  lc3b_mem_wmask     wmask_q;
  logic              err_q;

  logic              req;
  logic              cur_write;
  lc3b_word_index    cur_idx;
  logic              cur_err;
  logic              rd_en;
  lc3b_mem_wmask     wr_be;
  lc3b_word          ram_q;
  logic              unused_bits;

  assign req         = mem_read | mem_write;
  assign unused_bits = ^{mem_address[0], idx_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == '0) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request latches and latency counter; write wins when read and write are both high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          cnt     <= CNT_INIT;
          write_q <= mem_write;
          idx_q   <= mem_address[15:1];
          wdata_q <= mem_wdata;
          wmask_q <= mem_wmask;
          err_q   <= cur_err;
        end
        WAIT: if (cnt != '0) cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // The read is launched on the edge entering RESP so the registered RAM output
  // is valid during RESP; with LATENCY==1 that edge is the request-sampling edge.
  always_comb begin
    mem_resp  = (state == RESP);
    cur_write = (state == IDLE) ? mem_write : write_q;
    cur_idx   = (state == IDLE) ? mem_address[15:1] : idx_q;
`ifdef LC3B_MEMRESP_RANGECHK_EN
    cur_err   = (32'(cur_idx) >= DEPTH_WORDS);
    mem_err   = (state == RESP) && err_q;
`else
    cur_err   = 1'b0;
`endif
    rd_en     = (next_state == RESP) && !cur_write;
    wr_be     = (state == RESP && write_q && !err_q) ? wmask_q : '0;
  end

  lc3b_byte_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en   (rd_en),
    .rd_addr (cur_idx[AW-1:0]),
    .wr_be   (wr_be),
    .wr_addr (idx_q[AW-1:0]),
    .wdata   (wdata_q),
    .rdata   (ram_q)
  );

`ifdef LC3B_MEMRESP_RANGECHK_EN
  // Out-of-range reads return zero and keep returning it until the next read.
  logic rd_zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_zero_q <= 1'b0;
    else if (rd_en) rd_zero_q <= cur_err;
  end

  assign mem_rdata = rd_zero_q ? '0 : ram_q;
`else
  assign mem_rdata = ram_q;
`endif

endmodule
